maple_link_ctrl: RTL and testbench

Half-duplex link sequencer for the Maple bus port. It sits between the FIFO bridge and the transmitter/receiver pair. It grants the transmitter the bus only after the lines have been quiet for a set time, and opens a bounded response window after each host frame. It reports completion, unsolicited frames and response timeouts upstream.

---
 rtl/maple_pkg.sv | 28 ++
 rtl/maple_quiet_det.sv | 54 +++++
 rtl/maple_link_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_maple_link_ctrl.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/maple_pkg.sv
`default_nettype none
// ============================================================================
// Module      : maple_pkg
// Description : Shared types and default timing constants for the Maple bus
//               link sequencer and its bus-quiet detector.
// Revision    : 1.0 - initial release
// ============================================================================
package maple_pkg;

  // Link sequencer states
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_TX_START  = 3'd1,
    ST_TX_RUN    = 3'd2,
    ST_RESP_WAIT = 3'd3,
    ST_RX        = 3'd4
  } state_e;

  // Default timing, in clk cycles
  localparam int DEF_QUIET_CYCLES  = 16;
  localparam int DEF_START_TIMEOUT = 255;
  localparam int DEF_RESP_TIMEOUT  = 50000;

  // Width of the shared timeout counter; must hold DEF_RESP_TIMEOUT
  localparam int CNT_W = 16;

endpackage
`default_nettype wire

// File: rtl/maple_quiet_det.sv
`default_nettype none
// ============================================================================
// Module      : maple_quiet_det
// Description : Saturating bus-quiet counter. Counts consecutive cycles with
//               both Maple lines high and the receiver idle; quiet_ok is high
//               once the count has reached QUIET_CYCLES.
// Ports       : clk, reset  - clock, asynchronous active-high reset
//               sdcka/sdckb - synchronised bus lines
//               rx_busy     - receiver busy (a frame in progress is not quiet)
//               clr         - restart the quiet period
//               quiet_ok    - bus has been quiet for QUIET_CYCLES cycles
// Revision    : 1.0 - initial release
// ============================================================================
module maple_quiet_det
  import maple_pkg::*;
#(
  parameter int QUIET_CYCLES = DEF_QUIET_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic sdcka,
  input  logic sdckb,
  input  logic rx_busy,
  input  logic clr,
  output logic quiet_ok
);

  localparam int QW = $clog2(QUIET_CYCLES + 1);
  localparam logic [QW-1:0] C_QUIET_MAX = QW'(QUIET_CYCLES);

  logic [QW-1:0] count_q;
  logic [QW-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr || !(sdcka && sdckb && !rx_busy)) begin
      count_d = '0;
    end else if (count_q != C_QUIET_MAX) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign quiet_ok = (count_q == C_QUIET_MAX);

endmodule
`default_nettype wire

// File: rtl/maple_link_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : maple_link_ctrl
// Description : Half-duplex Maple bus link sequencer. Grants the transmitter
//               the bus after a quiet period, opens a bounded response window
//               after each host frame and reports completion, unsolicited
//               frames and timeouts upstream. All outputs are registered.
// Ports       : clk, reset   - clock, asynchronous active-high reset
//               sdcka/sdckb  - synchronised bus lines
//               tx_req       - level, a frame is ready to send
//               abort        - pulse, return to IDLE from any state
//               tx_busy      - transmitter busy
//               rx_busy      - receiver busy
//               tx_enable    - start/hold request to the transmitter
//               rx_arm       - receiver may observe the bus lines
//               link_busy    - sequencer not in IDLE
//               tx_done, rx_done, resp_timeout, start_err - 1-cycle pulses
// Revision    : 1.0 - initial release
// ============================================================================
module maple_link_ctrl
  import maple_pkg::*;
#(
  parameter int QUIET_CYCLES  = DEF_QUIET_CYCLES,
  parameter int START_TIMEOUT = DEF_START_TIMEOUT,
  parameter int RESP_TIMEOUT  = DEF_RESP_TIMEOUT,
  parameter int CNT_W         = maple_pkg::CNT_W
) (
  input  logic clk,
  input  logic reset,
  input  logic sdcka,
  input  logic sdckb,
  input  logic tx_req,
  input  logic abort,
  input  logic tx_busy,
  input  logic rx_busy,
  output logic tx_enable,
  output logic rx_arm,
  output logic link_busy,
  output logic tx_done,
  output logic rx_done,
  output logic resp_timeout,
  output logic start_err
);

  localparam logic [CNT_W-1:0] C_START_LIMIT = CNT_W'(START_TIMEOUT);
  localparam logic [CNT_W-1:0] C_RESP_LIMIT  = CNT_W'(RESP_TIMEOUT);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tx_enable_q, tx_enable_d;
  logic             rx_arm_q, rx_arm_d;
  logic             link_busy_q, link_busy_d;
  logic             tx_done_q, tx_done_d;
  logic             rx_done_q, rx_done_d;
  logic             resp_timeout_q, resp_timeout_d;
  logic             start_err_q, start_err_d;
  logic             quiet_clr;
  logic             quiet_ok;

  maple_quiet_det #(
    .QUIET_CYCLES (QUIET_CYCLES)
  ) u_quiet (
    .clk      (clk),
    .reset    (reset),
    .sdcka    (sdcka),
    .sdckb    (sdckb),
    .rx_busy  (rx_busy),
    .clr      (quiet_clr),
    .quiet_ok (quiet_ok)
  );

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    tx_done_d      = 1'b0;
    rx_done_d      = 1'b0;
    resp_timeout_d = 1'b0;
    start_err_d    = 1'b0;
    quiet_clr      = 1'b0;

    if (abort) begin
      state_d   = ST_IDLE;
      cnt_d     = '0;
      quiet_clr = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          cnt_d = '0;
          // An unsolicited frame takes the bus; a pending tx_req waits.
          if (rx_busy) begin
            state_d = ST_RX;
          end else if (tx_req && quiet_ok) begin
            state_d = ST_TX_START;
          end
        end
        ST_TX_START: begin
          if (tx_busy) begin
            state_d = ST_TX_RUN;
            cnt_d   = '0;
          end else if (cnt_q == C_START_LIMIT) begin
            start_err_d = 1'b1;
            state_d     = ST_IDLE;
            cnt_d       = '0;
            // A failed start must wait out a fresh quiet period before retry.
            quiet_clr   = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_TX_RUN: begin
          if (!tx_busy) begin
            tx_done_d = 1'b1;
            state_d   = ST_RESP_WAIT;
            cnt_d     = '0;
            quiet_clr = 1'b1;
          end
        end
        ST_RESP_WAIT: begin
          // A response starting on the expiry cycle still wins.
          if (rx_busy) begin
            state_d = ST_RX;
            cnt_d   = '0;
          end else if (cnt_q == C_RESP_LIMIT) begin
            resp_timeout_d = 1'b1;
            state_d        = ST_IDLE;
            cnt_d          = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_RX: begin
          if (!rx_busy) begin
            rx_done_d = 1'b1;
            state_d   = ST_IDLE;
            quiet_clr = 1'b1;
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end

    // Level outputs follow the next state so they change on the same edge
    // as the transition.
    tx_enable_d = (state_d == ST_TX_START) || (state_d == ST_TX_RUN);
    rx_arm_d    = !tx_enable_d;
    link_busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      cnt_q          <= '0;
      tx_enable_q    <= 1'b0;
      rx_arm_q       <= 1'b1;
      link_busy_q    <= 1'b0;
      tx_done_q      <= 1'b0;
      rx_done_q      <= 1'b0;
      resp_timeout_q <= 1'b0;
      start_err_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      tx_enable_q    <= tx_enable_d;
      rx_arm_q       <= rx_arm_d;
      link_busy_q    <= link_busy_d;
      tx_done_q      <= tx_done_d;
      rx_done_q      <= rx_done_d;
      resp_timeout_q <= resp_timeout_d;
      start_err_q    <= start_err_d;
    end
  end

  assign tx_enable    = tx_enable_q;
  assign rx_arm       = rx_arm_q;
  assign link_busy    = link_busy_q;
  assign tx_done      = tx_done_q;
  assign rx_done      = rx_done_q;
  assign resp_timeout = resp_timeout_q;
  assign start_err    = start_err_q;

endmodule
`default_nettype wire

// File: tb/tb_maple_link_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_maple_link_ctrl
// Description : Directed self-checking bench for maple_link_ctrl. The response
//               window is shortened to 1000 cycles to keep runs short; the
//               other timing parameters keep their defaults (16 / 255).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_maple_link_ctrl;

  localparam int RESP_TO = 1000;

  logic clk = 1'b0;
  logic reset, sdcka, sdckb, tx_req, abort, tx_busy, rx_busy;
  logic tx_enable, rx_arm, link_busy, tx_done, rx_done, resp_timeout, start_err;

  int n_checks = 0;
  int n_fail   = 0;
  logic seen_rt, seen_done, seen_se;

  maple_link_ctrl #(
    .QUIET_CYCLES  (16),
    .START_TIMEOUT (255),
    .RESP_TIMEOUT  (RESP_TO),
    .CNT_W         (16)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .sdcka        (sdcka),
    .sdckb        (sdckb),
    .tx_req       (tx_req),
    .abort        (abort),
    .tx_busy      (tx_busy),
    .rx_busy      (rx_busy),
    .tx_enable    (tx_enable),
    .rx_arm       (rx_arm),
    .link_busy    (link_busy),
    .tx_done      (tx_done),
    .rx_done      (rx_done),
    .resp_timeout (resp_timeout),
    .start_err    (start_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Advance n clock edges; sample 1 time unit after each edge.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // As tick, but accumulate any pulse seen into sticky flags.
  task automatic tick_watch(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      seen_rt   = seen_rt | resp_timeout;
      seen_done = seen_done | tx_done | rx_done;
      seen_se   = seen_se | start_err;
    end
  endtask

  task automatic clear_seen();
    seen_rt   = 1'b0;
    seen_done = 1'b0;
    seen_se   = 1'b0;
  endtask

  // Bounded wait for tx_enable to rise.
  task automatic wait_te(input int max);
    logic got;
    got = 1'b0;
    for (int i = 0; i < max && !got; i++) begin
      tick(1);
      if (tx_enable === 1'b1) got = 1'b1;
    end
    check("wait_tx_enable", got, 1'b1);
  endtask

  // Run one short host frame and stop on the tx_done edge.
  task automatic do_tx();
    tx_req = 1'b1;
    wait_te(40);
    tx_req  = 1'b0;
    tx_busy = 1'b1;
    tick(5);
    tx_busy = 1'b0;
    tick(1);
    check("do_tx_done", tx_done, 1'b1);
  endtask

  initial begin
    reset = 1'b1; sdcka = 1'b1; sdckb = 1'b1;
    tx_req = 1'b0; abort = 1'b0; tx_busy = 1'b0; rx_busy = 1'b0;
    clear_seen();
    tick(3);
    check("rst_tx_enable", tx_enable, 1'b0);
    check("rst_rx_arm", rx_arm, 1'b1);
    check("rst_link_busy", link_busy, 1'b0);
    check("rst_pulses", tx_done | rx_done | resp_timeout | start_err, 1'b0);

    // 1: quiet period then grant; 40-cycle frame
    tx_req = 1'b1;
    reset  = 1'b0;
    tick(16);
    check("t1_te_before_quiet", tx_enable, 1'b0);
    tick(1);
    check("t1_te_grant", tx_enable, 1'b1);
    check("t1_rx_arm_low", rx_arm, 1'b0);
    check("t1_link_busy", link_busy, 1'b1);
    tx_req  = 1'b0;
    tx_busy = 1'b1;
    tick(1);
    check("t1_te_hold", tx_enable, 1'b1);
    tick(39);
    tx_busy = 1'b0;
    tick(1);
    check("t1_tx_done", tx_done, 1'b1);
    check("t1_te_drop", tx_enable, 1'b0);
    check("t1_rx_arm_back", rx_arm, 1'b1);
    tick(1);
    check("t1_tx_done_1cyc", tx_done, 1'b0);
    check("t1_resp_wait_busy", link_busy, 1'b1);

    // 2: response at cycle 100 of the window, 200 cycles long
    tick(99);
    rx_busy = 1'b1;
    clear_seen();
    tick_watch(200);
    check("t2_no_timeout", seen_rt, 1'b0);
    check("t2_rx_arm", rx_arm, 1'b1);
    rx_busy = 1'b0;
    tick(1);
    check("t2_rx_done", rx_done, 1'b1);
    check("t2_idle_now", link_busy, 1'b0);
    tick(1);
    check("t2_rx_done_1cyc", rx_done, 1'b0);
    check("t2_idle_next", link_busy, 1'b0);

    // 3a: no response, window expires
    do_tx();
    clear_seen();
    tick_watch(RESP_TO);
    check("t3_no_early_timeout", seen_rt, 1'b0);
    check("t3_busy_before_expiry", link_busy, 1'b1);
    tick(1);
    check("t3_resp_timeout", resp_timeout, 1'b1);
    check("t3_idle", link_busy, 1'b0);
    tick(1);
    check("t3_timeout_1cyc", resp_timeout, 1'b0);

    // 3b: response starts exactly on the expiry cycle
    do_tx();
    clear_seen();
    tick_watch(RESP_TO);
    rx_busy = 1'b1;
    tick_watch(1);
    check("t3b_no_timeout", seen_rt, 1'b0);
    check("t3b_in_rx", link_busy, 1'b1);
    check("t3b_rx_arm", rx_arm, 1'b1);
    rx_busy = 1'b0;
    tick(1);
    check("t3b_rx_done", rx_done, 1'b1);

    // 4: transmitter never starts
    tx_req = 1'b1;
    wait_te(40);
    clear_seen();
    tick_watch(255);
    check("t4_no_early_err", seen_se, 1'b0);
    check("t4_te_held", tx_enable, 1'b1);
    tick(1);
    check("t4_start_err", start_err, 1'b1);
    check("t4_te_drop", tx_enable, 1'b0);
    check("t4_idle", link_busy, 1'b0);
    tick(16);
    check("t4_no_retry_yet", tx_enable, 1'b0);
    check("t4_err_1cyc", start_err, 1'b0);
    tick(1);
    check("t4_retry", tx_enable, 1'b1);

    // 6a: abort mid TX_RUN
    tx_req  = 1'b0;
    tx_busy = 1'b1;
    tick(6);
    clear_seen();
    abort = 1'b1;
    tick_watch(1);
    abort = 1'b0;
    check("t6a_te_drop", tx_enable, 1'b0);
    check("t6a_rx_arm", rx_arm, 1'b1);
    check("t6a_idle", link_busy, 1'b0);
    tick_watch(3);
    tx_busy = 1'b0;
    tick_watch(3);
    check("t6a_no_done", seen_done, 1'b0);

    // 5: tx_req and rx_busy together in IDLE
    tx_req  = 1'b1;
    rx_busy = 1'b1;
    tick(1);
    check("t5_rx_entered", link_busy, 1'b1);
    check("t5_te_low", tx_enable, 1'b0);
    check("t5_rx_arm", rx_arm, 1'b1);
    tick(10);
    check("t5_te_still_low", tx_enable, 1'b0);
    rx_busy = 1'b0;
    tick(1);
    check("t5_rx_done", rx_done, 1'b1);
    tick(16);
    check("t5_te_wait_quiet", tx_enable, 1'b0);
    tick(1);
    check("t5_te_served", tx_enable, 1'b1);

    // 6b: abort mid RESP_WAIT
    tx_req  = 1'b0;
    tx_busy = 1'b1;
    tick(3);
    tx_busy = 1'b0;
    tick(1);
    check("t6b_tx_done", tx_done, 1'b1);
    tick(10);
    clear_seen();
    abort = 1'b1;
    tick_watch(1);
    abort = 1'b0;
    check("t6b_idle", link_busy, 1'b0);
    check("t6b_rx_arm", rx_arm, 1'b1);
    tick_watch(RESP_TO + 100);
    check("t6b_no_timeout", seen_rt, 1'b0);
    check("t6b_no_done", seen_done, 1'b0);

    // 6c: asynchronous reset mid RX
    rx_busy = 1'b1;
    tick(1);
    check("t6c_in_rx", link_busy, 1'b1);
    tick(3);
    #2;
    reset = 1'b1;
    #1;
    check("t6c_async_busy", link_busy, 1'b0);
    check("t6c_async_te", tx_enable, 1'b0);
    check("t6c_async_rx_arm", rx_arm, 1'b1);
    rx_busy = 1'b0;
    clear_seen();
    tick_watch(2);
    reset = 1'b0;
    tick_watch(3);
    check("t6c_no_pulse", seen_done | seen_rt | seen_se, 1'b0);
    check("t6c_idle", link_busy, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
